axis_frame_packer: RTL and testbench
====================================

Name: axis_frame_packer

Overview:
- Downstream neighbour of the AXI4-Stream decimator.
- Consumes the decimated sample stream and groups it into frames of cfg_data beats, asserting m_axis_tlast on the final beat of each frame. This lets a DMA/writer stage close one transfer per frame.
- Contains a 2-entry skid buffer, so ready is fully registered with no combinational path from m_axis_tready to s_axis_tready.
- Reports a running completed-frame count.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of the data path in bits.
- CNTR_WIDTH, 32, width of the frame-length config, the beat counter and the frame counter.

Ports:
- aclk  in  1  system clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_data  in  CNTR_WIDTH  frame length in beats; 0 and 1 both mean every beat is tlast.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; registered.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output sample; registered.
- m_axis_tvalid  out  1  output valid; registered.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the last beat of each frame.
- sts_data  out  CNTR_WIDTH  count of completed frames (accepted tlast beats); wraps modulo 2^CNTR_WIDTH.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
  - sts_data=0, beat counter=0, frame length register=0, FSM=IDLE, skid buffer empty.
  - On the first clock edge after reset release, s_axis_tready goes to 1.
- Input acceptance: when s_axis_tvalid && s_axis_tready. Output acceptance: when m_axis_tvalid && m_axis_tready.
- Framing FSM, advanced on input acceptance only:
  - IDLE: on an accepted beat, latch len = max(cfg_data,1) and evaluate that beat as beat 0.
    - If len==1, tag it tlast and stay in IDLE.
    - Otherwise set cnt=1 and go to ACTIVE.
  - ACTIVE: on an accepted beat, tag it tlast iff cnt==len-1.
    - If tagged, set cnt=0 and go to IDLE.
    - Otherwise cnt=cnt+1.
  - cfg_data is sampled only at frame start. Changes during ACTIVE take effect at the next frame; the current frame is never truncated or extended.
- Data path:
  - tlast is computed at input acceptance and stored alongside tdata.
  - The output register and skid register each hold {tdata, tlast}.
  - Latency is 1 cycle from input acceptance to m_axis_tvalid when the output register is empty or being drained.
  - Throughput is 1 beat/cycle while m_axis_tready=1.
- Skid rules:
  - If the output register is full and not accepted while an input beat arrives, that beat goes to the skid register and s_axis_tready drops next cycle.
  - When the output is accepted with the skid register full, the skid contents move to the output and s_axis_tready rises next cycle.
  - Simultaneous input accept and output accept with skid empty: the new beat goes directly into the output register.
  - No beat is ever lost, duplicated or reordered.
- sts_data increments by 1 on each output acceptance with m_axis_tlast=1, wrapping from all-ones to 0.
- Backpressure never alters frame boundaries; tlast position depends only on accepted input beat count.
- Reset mid-frame discards buffered beats and the partial frame; the first beat after reset starts a new frame.

Decomposition:
- No shared package is required; widths are parameters.
- One natural sub-module: axis_skid_buffer, a 2-entry register slice parameterised by payload width (AXIS_TDATA_WIDTH+1), with the same clock and asynchronous reset.
- The framing FSM and frame counter stay in axis_frame_packer.

Test Plan:
- cfg_data=4, continuous valid, m_axis_tready=1, inputs 0..11 -> outputs 0..11 one cycle later; tlast on 3, 7, 11; sts_data=3; no bubbles.
- cfg_data=0, then 1, 5 beats each -> every output beat has tlast=1; sts_data=10.
- cfg_data=3, m_axis_tready toggling 1,0,0,1 pattern, 9 beats -> s_axis_tready drops only when both entries are full; output order 0..8 intact; tlast on 2, 5, 8.
- cfg_data=4; change to 2 after beat 1 of a frame -> that frame ends at beat 3 (tlast on 3); following frames tlast on 5, 7.
- cfg_data=5; assert aresetn low for 1 cycle mid-cycle after beat 2 with a beat buffered -> outputs immediately invalid, sts_data=0; next inputs 100..104 give tlast on 104.
- Frame-counter wrap with CNTR_WIDTH=4, cfg_data=1, 17 beats -> sts_data reads 1 after the last beat.

Source files
------------

// File: rtl/axis_frame_packer_pkg.sv
// Shared types and default widths for the frame packer slice.
package axis_frame_packer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_CNTR_WIDTH  = 32;

endpackage

// File: rtl/axis_frame_packer_if.sv
// AXI4-Stream beat bundle; master drives data/valid/last, slave drives ready.
import axis_frame_packer_pkg::*;

interface axis_frame_packer_if #(
  parameter int DATA_W = DEF_TDATA_WIDTH
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// 2-entry register slice: 1-cycle latency, registered in_rdy that drops only
// while both entries hold data, so out_rdy never reaches in_rdy combinationally.
module axis_skid_buffer
  import axis_frame_packer_pkg::*;
#(
  parameter int WIDTH = DEF_TDATA_WIDTH + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] skid_dat;
  logic             skid_vld;
  logic             skid_vld_nxt;
  logic             in_acc;
  logic             out_load;

  assign in_acc   = in_vld & in_rdy;
  assign out_load = ~out_vld | out_rdy;

  // The skid entry only fills when the output is stalled; it empties as soon
  // as the output register can take a new beat.
  always_comb begin
    skid_vld_nxt = skid_vld;
    if (out_load) begin
      skid_vld_nxt = 1'b0;
    end else if (in_acc) begin
      skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_dat  <= '0;
      out_vld  <= 1'b0;
      skid_dat <= '0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b0;
    end else begin
      in_rdy   <= ~skid_vld_nxt;
      skid_vld <= skid_vld_nxt;
      if (out_load) begin
        if (skid_vld) begin
          out_dat <= skid_dat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= in_acc;
          if (in_acc) begin
            out_dat <= in_dat;
          end
        end
      end else if (in_acc) begin
        skid_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/axis_frame_packer.sv
// Groups an AXI4-Stream into frames of cfg_data beats (tlast on the final beat)
// and counts completed frames; 1-cycle latency through a 2-entry skid slice.
module axis_frame_packer
  import axis_frame_packer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int CNTR_WIDTH       = DEF_CNTR_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  axis_frame_packer_if.slave    s_axis,
  axis_frame_packer_if.master   m_axis,
  output logic [CNTR_WIDTH-1:0] sts_data
);

  localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  frame_state_t            state;
  logic [CNTR_WIDTH-1:0]   cnt;
  logic [CNTR_WIDTH-1:0]   len;
  logic [CNTR_WIDTH-1:0]   cfg_len;
  logic                    in_acc;
  logic                    in_rdy;
  logic                    beat_last;
  logic [AXIS_TDATA_WIDTH:0] out_dat;
  logic                    out_vld;

  // A zero length would never close a frame, so treat it like one.
  assign cfg_len = (cfg_data == '0) ? ONE : cfg_data;
  assign in_acc  = s_axis.tvalid & in_rdy;

  always_comb begin
    beat_last = 1'b0;
    if (state == IDLE) begin
      beat_last = (cfg_len == ONE);
    end else begin
      beat_last = (cnt == len - ONE);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else if (in_acc) begin
      if (state == IDLE) begin
        len <= cfg_len;
        if (!beat_last) begin
          cnt   <= ONE;
          state <= ACTIVE;
        end
      end else if (beat_last) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_data <= '0;
    end else if (out_vld && m_axis.tready && out_dat[0]) begin
      sts_data <= sts_data + ONE;
    end
  end

  axis_skid_buffer #(
    .WIDTH (AXIS_TDATA_WIDTH + 1)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_dat  ({s_axis.tdata, beat_last}),
    .in_vld  (s_axis.tvalid),
    .in_rdy  (in_rdy),
    .out_dat (out_dat),
    .out_vld (out_vld),
    .out_rdy (m_axis.tready)
  );

  assign s_axis.tready = in_rdy;
  assign m_axis.tdata  = out_dat[AXIS_TDATA_WIDTH:1];
  assign m_axis.tlast  = out_dat[0];
  assign m_axis.tvalid = out_vld;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer: framing, skid backpressure, reset, counter wrap.
module tb_axis_frame_packer;

  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int DW2 = 8;
  localparam int CW2 = 4;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [CW-1:0]  cfg_data;
  logic [CW-1:0]  sts_data;
  logic [CW2-1:0] cfg2;
  logic [CW2-1:0] sts2;

  axis_frame_packer_if #(.DATA_W(DW))  s_if ();
  axis_frame_packer_if #(.DATA_W(DW))  m_if ();
  axis_frame_packer_if #(.DATA_W(DW2)) s2_if ();
  axis_frame_packer_if #(.DATA_W(DW2)) m2_if ();

  axis_frame_packer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg_data),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .sts_data (sts_data)
  );

  axis_frame_packer #(.AXIS_TDATA_WIDTH(DW2), .CNTR_WIDTH(CW2)) dut_wrap (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg2),
    .s_axis   (s2_if),
    .m_axis   (m2_if),
    .sts_data (sts2)
  );

  int passed = 0;
  int total  = 0;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   obs_q[$];
  logic [DW-1:0] in_q[$];
  int first_acc, first_out, last_out, rdy_viol;
  bit saw_stall;

  task automatic apply_reset();
    s_if.tvalid  = 1'b0;
    m_if.tready  = 1'b0;
    s2_if.tvalid = 1'b0;
    m2_if.tready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  // Drives in_q into the DUT from negedge to negedge and records accepted output beats.
  task automatic run(input int rdy_mode, input int sw_after, input logic [CW-1:0] sw_cfg,
                     input int budget);
    int n_exp = exp_q.size();
    int nacc  = 0;
    int occ   = 0;
    obs_q.delete();
    first_acc = -1; first_out = -1; last_out = -1; rdy_viol = 0; saw_stall = 0;
    for (int c = 0; c < budget && obs_q.size() < n_exp; c++) begin
      s_if.tvalid = (in_q.size() > 0);
      s_if.tdata  = (in_q.size() > 0) ? in_q[0] : '0;
      m_if.tready = (rdy_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (s_if.tready !== (occ < 2)) rdy_viol++;
      if (!s_if.tready) saw_stall = 1'b1;
      if (m_if.tvalid && m_if.tready) begin
        obs_q.push_back({m_if.tdata, m_if.tlast});
        if (first_out < 0) first_out = c;
        last_out = c;
        occ--;
      end
      if (s_if.tvalid && s_if.tready) begin
        void'(in_q.pop_front());
        if (first_acc < 0) first_acc = c;
        nacc++;
        occ++;
        if (nacc == sw_after) cfg_data = sw_cfg;
      end
      @(negedge aclk);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
  endtask

  task automatic test_reset();
    cfg_data = '0; cfg2 = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0; m2_if.tready = 1'b0;
    aresetn = 1'b0;
    #2;
    total++; if (m_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); else passed++;
    total++; if (m_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_if.tlast); else passed++;
    total++; if (m_if.tdata !== '0) $display("FAIL rst_tdata: got %h want 0", m_if.tdata); else passed++;
    total++; if (s_if.tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", s_if.tready); else passed++;
    total++; if (sts_data !== '0) $display("FAIL rst_sts: got %0d want 0", sts_data); else passed++;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    total++; if (s_if.tready !== 1'b1) $display("FAIL rst_tready_rise: got %b want 1", s_if.tready); else passed++;
  endtask

  task automatic test_basic();
    logic [DW:0] got, want;
    apply_reset();
    cfg_data = 4;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      in_q.push_back(DW'(i));
      exp_q.push_back({DW'(i), (i % 4 == 3)});
    end
    run(0, -1, '0, 100);
    for (int i = 0; i < 12; i++) begin
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (got !== want) $display("FAIL basic_beat%0d: got %h want %h", i, got, want); else passed++;
    end
    total++; if (first_out - first_acc != 1) $display("FAIL basic_latency: got %0d want 1", first_out - first_acc); else passed++;
    total++; if (last_out - first_out != 11) $display("FAIL basic_bubbles: span %0d want 11", last_out - first_out); else passed++;
    total++; if (sts_data !== 3) $display("FAIL basic_sts: got %0d want 3", sts_data); else passed++;
  endtask

  task automatic test_len01();
    logic [DW:0] got, want;
    apply_reset();
    exp_q.delete();
    cfg_data = 0;
    for (int i = 0; i < 5; i++) begin
      in_q.push_back(DW'(i + 20));
      exp_q.push_back({DW'(i + 20), 1'b1});
    end
    run(0, -1, '0, 50);
    cfg_data = 1;
    for (int i = 5; i < 10; i++) begin
      in_q.push_back(DW'(i + 20));
      exp_q.push_back({DW'(i + 20), 1'b1});
    end
    while (obs_q.size() > 0) void'(obs_q.pop_back());
    for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
    run(0, -1, '0, 50);
    for (int i = 5; i < 10; i++) begin
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (got !== want) $display("FAIL len01_beat%0d: got %h want %h", i, got, want); else passed++;
    end
    total++; if (sts_data !== 10) $display("FAIL len01_sts: got %0d want 10", sts_data); else passed++;
  endtask

  task automatic test_backpressure();
    logic [DW:0] got, want;
    apply_reset();
    cfg_data = 3;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      in_q.push_back(DW'(i));
      exp_q.push_back({DW'(i), (i % 3 == 2)});
    end
    run(1, -1, '0, 200);
    for (int i = 0; i < 9; i++) begin
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (got !== want) $display("FAIL bp_beat%0d: got %h want %h", i, got, want); else passed++;
    end
    total++; if (rdy_viol != 0) $display("FAIL bp_ready_rule: got %0d violations want 0", rdy_viol); else passed++;
    total++; if (saw_stall !== 1'b1) $display("FAIL bp_stall_seen: got %b want 1", saw_stall); else passed++;
    total++; if (sts_data !== 3) $display("FAIL bp_sts: got %0d want 3", sts_data); else passed++;
  endtask

  task automatic test_cfg_change();
    logic [DW:0] got, want;
    apply_reset();
    cfg_data = 4;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      in_q.push_back(DW'(i + 40));
      exp_q.push_back({DW'(i + 40), (i == 3 || i == 5 || i == 7)});
    end
    run(0, 2, 2, 100);
    for (int i = 0; i < 8; i++) begin
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (got !== want) $display("FAIL cfgchg_beat%0d: got %h want %h", i, got, want); else passed++;
    end
    total++; if (sts_data !== 3) $display("FAIL cfgchg_sts: got %0d want 3", sts_data); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [DW:0] got, want;
    int nacc = 0;
    cfg_data = 5;
    m_if.tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(nacc);
      if (s_if.tvalid && s_if.tready) nacc++;
      @(negedge aclk);
    end
    s_if.tvalid = 1'b0;
    total++; if (nacc != 2) $display("FAIL rmid_buffered: got %0d want 2", nacc); else passed++;
    total++; if (m_if.tvalid !== 1'b1) $display("FAIL rmid_pre_tvalid: got %b want 1", m_if.tvalid); else passed++;
    total++; if (s_if.tready !== 1'b0) $display("FAIL rmid_pre_tready: got %b want 0", s_if.tready); else passed++;
    aresetn = 1'b0;
    #1;
    total++; if (m_if.tvalid !== 1'b0) $display("FAIL rmid_tvalid: got %b want 0", m_if.tvalid); else passed++;
    total++; if (sts_data !== '0) $display("FAIL rmid_sts: got %0d want 0", sts_data); else passed++;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    total++; if (s_if.tready !== 1'b1) $display("FAIL rmid_tready: got %b want 1", s_if.tready); else passed++;
    exp_q.delete();
    for (int i = 100; i < 105; i++) begin
      in_q.push_back(DW'(i));
      exp_q.push_back({DW'(i), (i == 104)});
    end
    run(0, -1, '0, 50);
    for (int i = 100; i < 105; i++) begin
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++; if (got !== want) $display("FAIL rmid_beat%0d: got %h want %h", i, got, want); else passed++;
    end
    total++; if (sts_data !== 1) $display("FAIL rmid_sts_after: got %0d want 1", sts_data); else passed++;
  endtask

  task automatic test_wrap();
    int nacc  = 0;
    int nlast = 0;
    apply_reset();
    cfg2 = 4'd1;
    m2_if.tready = 1'b1;
    for (int c = 0; c < 60 && nacc < 17; c++) begin
      s2_if.tvalid = 1'b1;
      s2_if.tdata  = DW2'(nacc);
      if (m2_if.tvalid && m2_if.tready && m2_if.tlast) nlast++;
      if (s2_if.tvalid && s2_if.tready) nacc++;
      @(negedge aclk);
    end
    s2_if.tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (m2_if.tvalid && m2_if.tready && m2_if.tlast) nlast++;
      @(negedge aclk);
    end
    total++; if (nlast != 17) $display("FAIL wrap_tlast_count: got %0d want 17", nlast); else passed++;
    total++; if (sts2 !== 4'd1) $display("FAIL wrap_sts: got %0d want 1", sts2); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len01();
    test_backpressure();
    test_cfg_change();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
